// File: rtl/nanov_spi_pkg.sv
// Shared types and constants for the nanoV SPI memory front-end.
package nanov_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_END
  } spi_state_t;

  localparam logic [7:0] CMD_READ_DEF  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

  // Access size encodings as presented by the core; 3 also means a word.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/nanov_spi_bitclk.sv
// SPI bit timing: two clk cycles per bit (sck low, then high) and a
// per-state bit counter that wraps on the last bit of the current state.
module nanov_spi_bitclk #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] nbits,
  output logic             sck,
  output logic             bit_end,
  output logic             last_bit,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             phase_q;
  logic [CNT_W-1:0] cnt_q;

  // Phase toggles every cycle while running; the count advances as phase 1 ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else if (!run) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= ~phase_q;
      if (phase_q) cnt_q <= last_bit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign sck      = run & phase_q;
  assign bit_end  = run & phase_q;
  assign last_bit = (cnt_q == nbits - CNT_W'(1));
  assign bit_cnt  = cnt_q;

endmodule

// File: rtl/nanov_spi_mem.sv
// SPI RAM front-end for nanoV: command, address, then 1/2/4 data bytes.
// Reads stream each MISO bit to the core and also assemble rdata.
module nanov_spi_mem
  import nanov_spi_pkg::*;
#(
  parameter int         ADDR_BITS = 24,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_write,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [1:0]           size,
  input  logic [31:0]          wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 data_bit,
  output logic                 data_shift,
  output logic [31:0]          rdata,
  output logic                 spi_cs_n,
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  spi_state_t           state_q, state_d;
  logic                 accept;
  logic                 active;
  logic                 is_write_q;
  logic [1:0]           size_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          tx_sr_q;
  logic [31:0]          addr_word;
  logic [31:0]          wdata_swap;
  logic [2:0]           nbytes;
  logic [5:0]           nbits;
  logic                 sck_ph;
  logic                 bit_end;
  logic                 last_bit;
  logic [5:0]           bit_cnt;
  logic [4:0]           rx_idx;
  logic                 unused_cnt_msb;

  assign active = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign nbytes = size_bytes(size_q);

  // Address left-justified so it leaves MSB first from tx_sr_q[31].
  assign addr_word = 32'(addr_q) << (32 - ADDR_BITS);

  // Byte 0 goes out first, each byte MSB first.
  assign wdata_swap = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};

  // k-th received byte lands in rdata[8k+7:8k], MSB first within the byte.
  assign rx_idx         = {bit_cnt[4:3], ~bit_cnt[2:0]};
  assign unused_cnt_msb = bit_cnt[5];

  // Bit length of the state currently being shifted.
  always_comb begin
    nbits = 6'd8;
    case (state_q)
      ST_ADDR: nbits = 6'(ADDR_BITS);
      ST_DATA: nbits = {nbytes, 3'b000};
      default: nbits = 6'd8;
    endcase
  end

  nanov_spi_bitclk #(.CNT_W(6)) u_bitclk (
    .clk      (clk),
    .rst      (rst),
    .run      (active),
    .nbits    (nbits),
    .sck      (sck_ph),
    .bit_end  (bit_end),
    .last_bit (last_bit),
    .bit_cnt  (bit_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE, never queued.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = ST_CMD;
      end
      ST_CMD:  if (bit_end && last_bit) state_d = ST_ADDR;
      ST_ADDR: if (bit_end && last_bit) state_d = ST_DATA;
      ST_DATA: if (bit_end && last_bit) state_d = ST_END;
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_END);
  assign spi_cs_n = ~active;
  assign spi_sck  = sck_ph;
  assign spi_mosi = active & tx_sr_q[31];

  // Request capture on accept; payload only, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_write_q <= is_write;
      size_q     <= size;
      addr_q     <= addr;
      wdata_q    <= wdata;
    end
  end

  // Transmit shifter, reloaded at each state boundary; zeros during read data.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr_q <= {(is_write ? CMD_WRITE : CMD_READ), 24'd0};
    end else if (bit_end) begin
      if (last_bit && state_q == ST_CMD)       tx_sr_q <= addr_word;
      else if (last_bit && state_q == ST_ADDR) tx_sr_q <= is_write_q ? wdata_swap : 32'd0;
      else                                     tx_sr_q <= {tx_sr_q[30:0], 1'b0};
    end
  end

  // Read sampling at the end of each sck-high phase; rdata cleared on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bit   <= 1'b0;
      data_shift <= 1'b0;
      rdata      <= 32'd0;
    end else begin
      data_shift <= 1'b0;
      if (accept) begin
        rdata <= 32'd0;
      end else if (bit_end && state_q == ST_DATA && !is_write_q) begin
        data_bit      <= spi_miso;
        data_shift    <= 1'b1;
        rdata[rx_idx] <= spi_miso;
      end
    end
  end

endmodule

// File: tb/tb_nanov_spi_mem.sv
// Directed bench for nanov_spi_mem with a scoreboard for MOSI bytes,
// streamed read bits and assembled read data, plus a small SPI RAM model.
module tb_nanov_spi_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_write = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [1:0]  size = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, data_bit, data_shift;
  logic [31:0] rdata;
  logic        spi_cs_n, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  resp [4];
  logic [8:0]  mosi_q [$];
  logic        bit_q [$];
  logic [31:0] rdata_q [$];

  int          rise_cnt = 0;
  logic [7:0]  mosi_sr = 8'd0;
  logic [8:0]  exp_byte;
  logic [1:0]  exp_bit;
  int          d_idx;
  int          shift_total = 0;
  int          txn_total = 0;

  always #5 clk = ~clk;

  nanov_spi_mem dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_write   (is_write),
    .addr       (addr),
    .size       (size),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .data_bit   (data_bit),
    .data_shift (data_shift),
    .rdata      (rdata),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MOSI capture on sck rising edges, compared byte by byte.
  always @(posedge spi_sck or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      rise_cnt = 0;
      mosi_sr  = 8'd0;
    end else begin
      rise_cnt++;
      mosi_sr = {mosi_sr[6:0], spi_mosi};
      if (rise_cnt % 8 == 0) begin
        exp_byte = (mosi_q.size() > 0) ? mosi_q.pop_front() : 9'h1FF;
        check("mosi_byte", 32'({1'b0, mosi_sr}), 32'(exp_byte));
      end
    end
  end

  always @(negedge spi_cs_n) txn_total++;

  // RAM model: presents data bits while sck is low, after cmd+addr.
  always @(negedge clk) begin
    if (!spi_cs_n && !spi_sck && rise_cnt >= 32 && rise_cnt < 64) begin
      d_idx    = rise_cnt - 32;
      spi_miso = resp[d_idx / 8][7 - (d_idx % 8)];
    end
  end

  // Read strobe monitor.
  always @(negedge clk) begin
    if (data_shift === 1'b1) begin
      shift_total++;
      exp_bit = (bit_q.size() > 0) ? {1'b0, bit_q.pop_front()} : 2'b11;
      check("data_bit", 32'({1'b0, data_bit}), 32'(exp_bit));
    end
  end

  task automatic push_expect(input logic w, input logic [23:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
    int          n;
    logic [31:0] r;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mosi_q.push_back({1'b0, (w ? 8'h02 : 8'h03)});
    mosi_q.push_back({1'b0, a[23:16]});
    mosi_q.push_back({1'b0, a[15:8]});
    mosi_q.push_back({1'b0, a[7:0]});
    r = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (w) begin
        mosi_q.push_back({1'b0, wd[8*k +: 8]});
      end else begin
        mosi_q.push_back(9'h000);
        r[8*k +: 8] = resp[k];
        for (int b = 7; b >= 0; b--) bit_q.push_back(resp[k][b]);
      end
    end
    rdata_q.push_back(r);
  endtask

  task automatic drive_req(input logic w, input logic [23:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    is_write = w;
    addr     = a;
    size     = sz;
    wdata    = wd;
    start    = 1'b1;
  endtask

  task automatic issue(input logic w, input logic [23:0] a, input logic [1:0] sz,
                       input logic [31:0] wd);
    drive_req(w, a, sz, wd);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered one step after the accept edge (cycle 1 of the transaction).
  task automatic finish_txn(input string tag, input int exp_lat);
    int          cyc;
    logic [31:0] r;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    r = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hXXXX_XXXX;
    check({tag, "_rdata"}, rdata, r);
  endtask

  task automatic drained(input string tag, input int sh0, input int exp_sh);
    @(posedge clk); #1;
    check({tag, "_shifts"}, 32'(shift_total - sh0), 32'(exp_sh));
    check({tag, "_mosi_left"}, 32'(mosi_q.size()), 32'd0);
    check({tag, "_bits_left"}, 32'(bit_q.size()), 32'd0);
    check({tag, "_cs_idle"}, 32'(spi_cs_n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int sh0;
    int t0;
    int gap;

    resp = '{8'h00, 8'h00, 8'h00, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_shift", 32'(data_shift), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the middle of a write
    t0 = txn_total;
    push_expect(1'b1, 24'h001234, 2'd2, 32'hA1B2C3D4);
    issue(1'b1, 24'h001234, 2'd2, 32'hA1B2C3D4);
    cyc = 1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst_sck_hi", 32'(spi_sck), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    check("midrst_sck", 32'(spi_sck), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mosi_q.delete();
    bit_q.delete();
    rdata_q.delete();
    check("midrst_txns", 32'(txn_total - t0), 32'd1);
    @(posedge clk); #1;

    // Word write after reset
    sh0 = shift_total;
    t0  = txn_total;
    push_expect(1'b1, 24'h001234, 2'd2, 32'hA1B2C3D4);
    issue(1'b1, 24'h001234, 2'd2, 32'hA1B2C3D4);
    finish_txn("wr", 129);
    drained("wr", sh0, 0);
    check("wr_txns", 32'(txn_total - t0), 32'd1);

    // Byte read
    sh0  = shift_total;
    resp = '{8'h5A, 8'h00, 8'h00, 8'h00};
    push_expect(1'b0, 24'h000010, 2'd0, 32'd0);
    issue(1'b0, 24'h000010, 2'd0, 32'hFFFF_FFFF);
    finish_txn("rd1", 81);
    drained("rd1", sh0, 8);

    // Halfword read
    sh0  = shift_total;
    resp = '{8'h34, 8'h12, 8'h00, 8'h00};
    push_expect(1'b0, 24'h000020, 2'd1, 32'd0);
    issue(1'b0, 24'h000020, 2'd1, 32'd0);
    finish_txn("rd2", 97);
    drained("rd2", sh0, 16);

    // size=3 read behaves as a word
    sh0  = shift_total;
    resp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_expect(1'b0, 24'hABCDEF, 2'd3, 32'd0);
    issue(1'b0, 24'hABCDEF, 2'd3, 32'd0);
    finish_txn("rd4", 129);
    drained("rd4", sh0, 32);
    repeat (5) @(posedge clk);
    #1;
    check("rd4_rdata_hold", rdata, 32'hDEADBEEF);

    // start held high across two transactions
    sh0  = shift_total;
    t0   = txn_total;
    resp = '{8'hC3, 8'h00, 8'h00, 8'h00};
    push_expect(1'b0, 24'h000100, 2'd0, 32'd0);
    push_expect(1'b0, 24'h000100, 2'd0, 32'd0);
    drive_req(1'b0, 24'h000100, 2'd0, 32'd0);
    @(posedge clk); #1;
    finish_txn("hold1", 81);
    gap = 0;
    while (spi_cs_n === 1'b1 && gap < 10) begin
      gap++;
      @(posedge clk); #1;
    end
    check("hold_cs_gap", 32'(gap), 32'd2);
    finish_txn("hold2", 81);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("hold_txns", 32'(txn_total - t0), 32'd2);
    check("hold_busy", 32'(busy), 32'd0);
    drained("hold", sh0, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nanov_spi_mem.md
Name: nanov_spi_mem

Overview:
- Bit-serial SPI memory front-end for the nanoV core. Turns a core load/store request into a SPI RAM transaction: command, 24-bit address, then 1/2/4 data bytes.
- On writes it serialises the core's parallel store word onto MOSI.
- On reads it returns MISO bits one at a time with a shift strobe, in the form the core's serial data input and shift-enable consume. It also assembles a parallel copy of the read data.
- Sits between the core and the external SPI RAM pins.

Parameters:
- ADDR_BITS, 24, address width sent after the command, MSB first.
- CMD_READ, 8'h03, SPI RAM read opcode.
- CMD_WRITE, 8'h02, SPI RAM write opcode.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request strobe; accepted only when busy=0.
- is_write  in  1  1=store, 0=load; sampled on accept.
- addr  in  ADDR_BITS  byte address; sampled on accept.
- size  in  2  0=1 byte, 1=2 bytes, 2 or 3=4 bytes; sampled on accept.
- wdata  in  32  store data; sampled on accept.
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse at the end of a transaction.
- data_bit  out  1  most recently sampled MISO bit (read only).
- data_shift  out  1  one-cycle strobe; data_bit is valid in that cycle.
- rdata  out  32  assembled read data, little-endian.
- spi_cs_n  out  1  chip select, active low.
- spi_sck  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  serial data to RAM.
- spi_miso  in  1  serial data from RAM.

Behaviour:
- Reset (async, immediate), including mid-transaction:
  - state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - busy=0, done=0, data_bit=0, data_shift=0, rdata=0.
  - A truncated SPI transfer is acceptable.
- States and transitions: IDLE -> CMD (8 bits) -> ADDR (ADDR_BITS bits) -> DATA (8*N bits, N=1/2/4) -> END -> IDLE.
- Accept:
  - In IDLE with start=1, latch is_write, addr, size and wdata.
  - Clear rdata to 0.
  - Next cycle: state=CMD, spi_cs_n=0, bit phase 0.
- SPI bit timing: each bit takes 2 clk cycles.
  - Phase 0: spi_sck=0, spi_mosi driven with the current bit.
  - Phase 1: spi_sck=1, spi_mosi held.
  - Bit counter advances on the clk edge that ends phase 1.
  - spi_miso is sampled on that same edge.
- Bit order:
  - Command, then address: MSB first.
  - Write data: byte 0 (wdata[7:0]) first, each byte MSB first; then byte 1, and so on.
- MOSI during read DATA bits: 0.
- Read DATA phase, on each sample:
  - data_bit<=spi_miso, data_shift<=1 for exactly one cycle.
  - The k-th received byte fills rdata[8k+7:8k], MSB first.
  - Bytes that are not received stay 0. Sign extension is the core's job.
- Write DATA phase: data_shift stays 0 throughout.
- END state (one cycle): spi_cs_n=1, spi_sck=0, done=1, busy=1; then IDLE.
  - spi_cs_n is therefore high for at least 2 cycles between transactions.
- Latency from the accept edge to the done cycle: 2*(8+ADDR_BITS+8N)+1 cycles.
  - With ADDR_BITS=24: N=1 -> 81, N=2 -> 97, N=4 -> 129.
- start while busy (including in the END cycle) is ignored, not queued.
- rdata stays stable from done until the next accept.

Decomposition:
- Package nanov_spi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DATA, END);
  - the CMD_READ/CMD_WRITE defaults;
  - the size encodings;
  - a function mapping size to byte count.
- One sub-module, nanov_spi_bitclk, holds the phase toggle and bit counter. It generates sck, a bit-end strobe, and a last-bit-of-state flag.
- The top level keeps the FSM, the shift registers and rdata assembly.

Test Plan:
- Reset mid-write, asserting rst at cycle 40 -> same cycle: spi_cs_n=1, spi_sck=0, busy=0. After release, a new start is accepted normally.
- Write addr=0x001234, wdata=0xA1B2C3D4, size=2 -> MOSI bytes 02,00,12,34,D4,C3,B2,A1 across 64 sck rising edges; done at cycle 129; no data_shift pulses.
- Read addr=0x000010, size=0, RAM model returns 0x5A:
  - 8 data_shift pulses with data_bit sequence 0,1,0,1,1,0,1,0;
  - rdata=0x0000005A; done at cycle 81.
- Read size=1, model returns 0x34 then 0x12 -> rdata=0x00001234; done at cycle 97.
- Read size=3, model returns 0xEF,0xBE,0xAD,0xDE -> treated as 4 bytes; rdata=0xDEADBEEF; 32 strobes.
- start held high continuously across two transactions -> second transaction accepted only in IDLE, after END; spi_cs_n high for 2 cycles between them; start pulses during busy produce no extra transactions.
